// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode/funct
// constants, datapath select encodings, FSM state and instruction class.
package mips_mc_ctrl_pkg;

    // Primary opcodes (Instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (Instruction[5:0])
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // ExtOp encodings
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    // ALUctr encodings (2'b11 reserved)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;

    // nPC_sel encodings
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BEQ = 2'b01;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    // Instruction class: selects the path through the FSM.
    typedef enum logic [2:0] {
        CLS_ILL = 3'd0,
        CLS_ALU = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_J   = 3'd5
    } cls_e;

    // Datapath select word; held stable from ID through commit.
    typedef struct packed {
        logic       reg_dst;
        logic [1:0] ext_op;
        logic [1:0] npc_sel;
        logic [1:0] alu_ctr;
        logic       mem_to_reg;
        logic       alu_src;
        logic       j_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational op/funct decode into the datapath select word and the
// instruction class that steers the sequencing FSM. Anything not in the
// supported set decodes as illegal with an all-zero select word, so it
// commits as a plain PC+4 NOP.
module mips_decode
    import mips_mc_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output cls_e       cls_o
);

    // Opcode/funct to control word and class.
    always_comb begin
        ctrl_o = CTRL_NONE;
        cls_o  = CLS_ILL;
        case (op_i)
            OP_RTYPE: begin
                if (funct_i == FN_ADDU || funct_i == FN_SUBU) begin
                    cls_o          = CLS_ALU;
                    ctrl_o.reg_dst = 1'b1;
                    ctrl_o.ext_op  = EXT_ZERO;
                    ctrl_o.alu_ctr = (funct_i == FN_SUBU) ? ALU_SUB : ALU_ADD;
                    ctrl_o.alu_src = 1'b0;
                end
            end
            OP_ORI: begin
                cls_o          = CLS_ALU;
                ctrl_o.ext_op  = EXT_ZERO;
                ctrl_o.alu_ctr = ALU_OR;
                ctrl_o.alu_src = 1'b1;
            end
            OP_LUI: begin
                // rs is $0 for lui, so rs + (imm<<16) yields the upper immediate.
                cls_o          = CLS_ALU;
                ctrl_o.ext_op  = EXT_UPPER;
                ctrl_o.alu_ctr = ALU_ADD;
                ctrl_o.alu_src = 1'b1;
            end
            OP_LW: begin
                cls_o             = CLS_LW;
                ctrl_o.ext_op     = EXT_SIGN;
                ctrl_o.alu_ctr    = ALU_ADD;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                cls_o          = CLS_SW;
                ctrl_o.ext_op  = EXT_SIGN;
                ctrl_o.alu_ctr = ALU_ADD;
                ctrl_o.alu_src = 1'b1;
            end
            OP_BEQ: begin
                cls_o          = CLS_BEQ;
                ctrl_o.ext_op  = EXT_SIGN;
                ctrl_o.npc_sel = NPC_BEQ;
                ctrl_o.alu_ctr = ALU_SUB;
            end
            OP_J: begin
                cls_o        = CLS_J;
                ctrl_o.j_sel = 1'b1;
            end
            default: begin
                cls_o  = CLS_ILL;
                ctrl_o = CTRL_NONE;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control unit for mips_dp. Latches op/funct from Instruction
// in IF, then sequences ID/EX/MEM/WB and raises RegWr, MemWr and pc_en only
// in the commit cycle. Optional performance counters are built when the
// CTRL_PERF_EN macro is defined; otherwise cyc_cnt/instr_cnt read 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IF    | capture op/funct from Instruction, all outputs 0
// ID    | selects valid; j and illegal commit here
// EX    | beq commits here; lw/sw go to MEM, ALU ops to WB
// MEM   | wait for mem_rdy; sw commits on mem_rdy, lw goes to WB
// WB    | register write-back commit
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Instruction,
    input  logic             mem_rdy,
    output logic             RegDst,
    output logic             RegWr,
    output logic [1:0]       ExtOp,
    output logic [1:0]       nPC_sel,
    output logic [1:0]       ALUctr,
    output logic             MemtoReg,
    output logic             MemWr,
    output logic             ALUSrc,
    output logic             j_sel,
    output logic             pc_en,
    output logic             illegal,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    ctrl_t      ctrl;
    cls_e       cls;

    // Only the opcode and funct fields influence control.
    logic unused_instr;
    assign unused_instr = ^Instruction[25:6];

    mips_decode u_decode (
        .op_i    (op_q),
        .funct_i (funct_q),
        .ctrl_o  (ctrl),
        .cls_o   (cls)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode register: Instruction is only looked at while in IF.
    always_comb begin
        op_d    = op_q;
        funct_d = funct_q;
        if (state_q == ST_IF) begin
            op_d    = Instruction[31:26];
            funct_d = Instruction[5:0];
        end
    end

    // Decode register update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IF: state_d = ST_ID;
            ST_ID: begin
                if (cls == CLS_J || cls == CLS_ILL) begin
                    state_d = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                if (cls == CLS_BEQ) begin
                    state_d = ST_IF;
                end else if (cls == CLS_LW || cls == CLS_SW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_rdy) begin
                    state_d = (cls == CLS_SW) ? ST_IF : ST_WB;
                end
            end
            ST_WB:   state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
    end

    // Outputs: selects from the decode register outside IF, strobes only in
    // the commit cycle. The MEM commit is the one path gated by mem_rdy.
    always_comb begin
        RegDst   = 1'b0;
        ExtOp    = 2'b00;
        nPC_sel  = 2'b00;
        ALUctr   = 2'b00;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        j_sel    = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        pc_en    = 1'b0;
        illegal  = 1'b0;
        if (state_q != ST_IF) begin
            RegDst   = ctrl.reg_dst;
            ExtOp    = ctrl.ext_op;
            nPC_sel  = ctrl.npc_sel;
            ALUctr   = ctrl.alu_ctr;
            MemtoReg = ctrl.mem_to_reg;
            ALUSrc   = ctrl.alu_src;
            j_sel    = ctrl.j_sel;
        end
        case (state_q)
            ST_ID: begin
                illegal = (cls == CLS_ILL);
                pc_en   = (cls == CLS_J) || (cls == CLS_ILL);
            end
            ST_EX: begin
                pc_en = (cls == CLS_BEQ);
            end
            ST_MEM: begin
                if (cls == CLS_SW && mem_rdy) begin
                    MemWr = 1'b1;
                    pc_en = 1'b1;
                end
            end
            ST_WB: begin
                RegWr = 1'b1;
                pc_en = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Counter increments; both wrap naturally.
    always_comb begin
        cyc_cnt_d   = cyc_cnt_q + CNT_ONE;
        instr_cnt_d = instr_cnt_q;
        if (pc_en) begin
            instr_cnt_d = instr_cnt_q + CNT_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cyc_cnt   = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit that sits directly upstream of `mips_dp`. It decodes the 32-bit `Instruction` returned by the datapath and sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath control input and a PC-advance enable `pc_en` for the IFU. It asserts the state-changing strobes (`RegWr`, `MemWr`, `pc_en`) only in the commit cycle, so the datapath can be run with slow or handshaked data memory.

## Interface
Parameters:
- `CNT_W`, 32, width of performance counters (only used with `CTRL_PERF_EN`).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `Instruction`  in  32  current instruction from `mips_dp`; stable while `pc_en`=0.
- `mem_rdy`  in  1  data-memory ready; completes a MEM-state access.
- `RegDst`  out  1  0=rt, 1=rd destination.
- `RegWr`  out  1  register-file write strobe (commit only).
- `ExtOp`  out  2  00 zero-ext, 01 sign-ext, 10 upper (imm<<16).
- `nPC_sel`  out  2  00 PC+4, 01 branch-if-zero.
- `ALUctr`  out  2  00 add, 01 sub, 10 or, 11 reserved.
- `MemtoReg`  out  1  1=write-back from memory.
- `MemWr`  out  1  data-memory write strobe (commit only).
- `ALUSrc`  out  1  1=immediate operand.
- `j_sel`  out  1  1=jump target.
- `pc_en`  out  1  PC update enable, one cycle per instruction.
- `illegal`  out  1  pulses in ID for an undecoded opcode/funct.
- `cyc_cnt`, `instr_cnt`  out  `CNT_W`  counters (only with `CTRL_PERF_EN`).

## Operation
- Supported instructions: addu (op 000000, funct 100001), subu (000000/100011), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010).
- States: IF, ID, EX, MEM, WB.
- Decode register: latched from `Instruction` on the IF→ID edge. All select outputs (`RegDst`, `ExtOp`, `nPC_sel`, `ALUctr`, `MemtoReg`, `ALUSrc`, `j_sel`) are driven from this register in ID..commit and are 0 in IF.
- Transitions:
  - IF→ID always.
  - ID: j commits (`pc_en`=1, `j_sel`=1), then →IF. Illegal instructions pulse `illegal`, commit as NOP (`pc_en`=1 only), then →IF. All others →EX.
  - EX: beq commits (`pc_en`=1, `nPC_sel`=01), then →IF. lw and sw →MEM. R-type, ori and lui →WB.
  - MEM: hold while `mem_rdy`=0. With `mem_rdy`=1: sw commits (`MemWr`=1, `pc_en`=1), then →IF; lw →WB.
  - WB: commits (`RegWr`=1, `pc_en`=1), then →IF.
- Cycle counts with `mem_rdy` tied high:
  - j and illegal: 2.
  - beq: 3.
  - R-type, ori, lui and sw: 4.
  - lw: 5.
- Every extra cycle of `mem_rdy`=0 in MEM adds one cycle.
- Exactly one `pc_en` pulse per instruction. `RegWr` and `MemWr` are never high simultaneously and never high outside the commit cycle.
- The decoded value of op 000000 with an unsupported funct is illegal. `illegal` does not stall.

## Timing
- Reset (`rst`=0 at a clock edge): state←IF, decode register←0, all outputs 0, counters 0. This applies in any state, including mid-MEM wait; the aborted instruction has no committed effect.
- Strobes and selects are registered or Moore outputs of state plus decode register. They have no combinational path from `Instruction` or `mem_rdy`, except the MEM-state commit, which is qualified by `mem_rdy` combinationally.
- `mem_rdy` is sampled only in MEM and ignored in all other states.
- `Instruction` is sampled only in IF.

## Configuration
- `CTRL_PERF_EN` defined:
  - `cyc_cnt` increments every cycle out of reset.
  - `instr_cnt` increments on each `pc_en`.
  - Both wrap modulo 2^`CNT_W`.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package: opcode/funct constants, the `ExtOp`, `ALUctr` and `nPC_sel` encodings, and the state enum.
- One sub-module, `mips_decode`: combinational op/funct → control-word and instruction-class decode. The FSM and counters live in `mips_mc_ctrl`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles mid-lw → all outputs 0, state IF; first instruction after release restarts at IF.
- addu $3,$1,$2 (0x00221821) → `pc_en` and `RegWr` both high in cycle 4 only; `RegDst`=1, `ALUctr`=00, `ALUSrc`=0.
- lw 0x8C220004 with `mem_rdy` low for 3 MEM cycles → commit in cycle 8; `MemtoReg`=1, `ExtOp`=01, `RegWr` in WB.
- sw 0xAC220004 → `MemWr` and `pc_en` high in cycle 4 only; `RegWr` stays 0.
- beq 0x10220003 commits in cycle 3 with `nPC_sel`=01, `ALUctr`=01. j 0x08000010 commits in cycle 2 with `j_sel`=1.
- Illegal opcode 0xFC000000 → `illegal` pulse and NOP `pc_en` in cycle 2. With `CTRL_PERF_EN`, after 10 mixed instructions `instr_cnt`=10 and `cyc_cnt` equals the elapsed cycle count.
